quant_stream: RTL
=================

QUANT_STREAM -- requirements
Module: quant_stream

Interface
REQ-001 Parameter IN_W, default 16, signed input sample width; legal range 4..32.
REQ-002 Parameter OUT_W, default 8, signed output sample width; legal range 4..16, OUT_W < IN_W.
REQ-003 Parameter LANES, default 4, samples per beat.
REQ-004 Parameter CNT_W, default 16, width of the saturation statistics counter.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  input beat valid.
REQ-008 in_ready  output  1  block can accept the beat this cycle.
REQ-009 in_data  input  LANES*IN_W  packed signed samples; lane i at bits [i*IN_W +: IN_W].
REQ-010 in_shift  input  5  right-shift amount; sampled with the beat.
REQ-011 in_mode  input  2  0=INT-OUT_W, 1=INT4, 2=binary, 3=bypass-truncate; sampled with the beat.
REQ-012 out_valid  output  1  output beat valid.
REQ-013 out_ready  input  1  downstream accepts the beat.
REQ-014 out_data  output  LANES*OUT_W  packed signed results, same lane order as in_data.
REQ-015 out_sat  output  LANES  per-lane flag: the lane saturated in this beat.
REQ-016 clr_stats  input  1  synchronous clear of sat_cnt.
REQ-017 sat_cnt  output  CNT_W  running count of saturated lanes.

Function
REQ-018 The pipeline SHALL be two registered stages: S1 rounds; S2 shifts, saturates and formats.
REQ-019 Each stage SHALL carry its own valid bit and the sampled shift and mode values.
REQ-020 Global advance SHALL be adv = !out_valid || out_ready; when adv=0, all stages hold.
REQ-021 in_ready SHALL equal adv, combinationally; a beat is accepted when in_valid && in_ready.
REQ-022 Latency SHALL be 2 cycles from acceptance to out_valid with out_ready held high; throughput SHALL be 1 beat/cycle.
REQ-023 out_data and out_sat SHALL remain stable while out_valid && !out_ready.
REQ-024 The effective shift SHALL be s = min(in_shift, IN_W).
REQ-025 Intermediate arithmetic SHALL be IN_W+2 bits signed, so that no overflow occurs.
REQ-026 Rounding SHALL be half away from zero when s>0: add 2^(s-1) if x>=0, else subtract 2^(s-1); the result is then arithmetic-shifted right by s.
REQ-027 When s=0 the value SHALL pass unrounded.
REQ-028 Mode 0 SHALL saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-029 Mode 1 SHALL saturate to [-8, 7], sign-extended to OUT_W.
REQ-030 Mode 2 SHALL output 1 if the raw input x>=0, else 0; shift is ignored and out_sat=0.
REQ-031 Mode 3 SHALL output the low OUT_W bits of the shifted value with no saturation, and out_sat=0.
REQ-032 out_sat[i] SHALL be 1 when lane i was clamped in mode 0 or mode 1.
REQ-033 On each output handshake, sat_cnt SHALL increment by popcount(out_sat) and stick at 2^CNT_W-1, never wrapping.
REQ-034 If clr_stats and a handshake occur in the same cycle, clr_stats SHALL win and sat_cnt becomes 0.

Reset
REQ-035 On rst, all stage valids, out_valid, out_data, out_sat and sat_cnt SHALL be 0; in_ready SHALL be 1 in the first cycle after reset.
REQ-036 Reset mid-stream SHALL discard in-flight beats; no beat emerges after reset that was accepted before it.
REQ-037 rst SHALL dominate clr_stats, in_valid and out_ready.

Verification
REQ-038 Rounding, mode 0, IN_W=16, OUT_W=8, shift=4, lanes {40, -40, 24, -24} -> out {3, -3, 2, -2}, out_sat=0, after 2 cycles.
REQ-039 Saturation, mode 0, shift=0, lanes {200, -200, 127, -128} -> out {127, -128, 127, -128}, out_sat=0b0011, sat_cnt += 2; the same beat in mode 1 -> {7, -8, 7, -8}, out_sat=0b1111.
REQ-040 Backpressure: stream 6 beats, out_ready low for 3 cycles mid-stream -> in_ready low while stalled, out_data held, all 6 beats delivered in order with none dropped or duplicated.
REQ-041 Corners: shift=31 with x=-32768 -> effective s=16, out -1 (no overflow); mode 2 with x=0 -> 1, with x=-1 -> 0.
REQ-042 Counter: preload sat_cnt near max with CNT_W=4 -> counter sticks at 15; clr_stats concurrent with a saturating handshake -> 0.
REQ-043 Reset: assert rst with 2 beats in flight -> out_valid 0 next cycle, and the flushed beats never appear.

Source files
------------

// File: rtl/quant_stream.sv
// rtl/quant_stream.sv - two-stage lane-parallel round/shift/saturate quantizer with saturation statistics
//
// Ports:
//   clk, rst                     rising-edge clock, synchronous active-high reset
//   in_valid / in_ready          input beat handshake; in_ready is the pipeline advance
//   in_data [LANES*IN_W]         packed signed samples, lane i at [i*IN_W +: IN_W]
//   in_shift [5], in_mode [2]    right-shift amount and output mode, captured with the beat
//   out_valid / out_ready        output beat handshake
//   out_data [LANES*OUT_W]       packed signed results, same lane order as in_data
//   out_sat [LANES]              per-lane clamp flag for the current output beat
//   clr_stats                    synchronous clear of sat_cnt
//   sat_cnt [CNT_W]              sticky-at-max count of saturated lanes over handshakes

module quant_stream #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_data,
  input  logic [4:0]             in_shift,
  input  logic [1:0]             in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic [LANES-1:0]       out_sat,
  input  logic                   clr_stats,
  output logic [CNT_W-1:0]       sat_cnt
);

  // Two guard bits: rounding bias of at most 2^(IN_W-1) can never overflow.
  localparam int W2    = IN_W + 2;
  localparam int SH_W  = 6;
  localparam int POP_W = $clog2(LANES + 1);
  localparam int SUM_W = CNT_W + POP_W;

  localparam logic [1:0] MODE_INT   = 2'd0;
  localparam logic [1:0] MODE_INT4  = 2'd1;
  localparam logic [1:0] MODE_BIN   = 2'd2;

  localparam logic signed [W2-1:0] M0_HI = W2'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [W2-1:0] M0_LO = W2'(-(2 ** (OUT_W - 1)));
  localparam logic signed [W2-1:0] M1_HI = W2'(7);
  localparam logic signed [W2-1:0] M1_LO = W2'(-8);
  localparam logic [CNT_W-1:0]     CNT_MAX = '1;

  // Stage 1: rounded (not yet shifted) value per lane plus captured controls.
  logic                   s1_valid_q, s1_valid_d;
  logic [SH_W-1:0]        s1_shift_q, s1_shift_d;
  logic [1:0]             s1_mode_q,  s1_mode_d;
  logic [LANES-1:0]       s1_neg_q,   s1_neg_d;
  logic signed [W2-1:0]   s1_val_q [LANES];
  logic signed [W2-1:0]   s1_val_d [LANES];

  // Stage 2: the output registers.
  logic                   out_valid_q, out_valid_d;
  logic [LANES*OUT_W-1:0] out_data_q,  out_data_d;
  logic [LANES-1:0]       out_sat_q,   out_sat_d;
  logic [CNT_W-1:0]       sat_cnt_q,   sat_cnt_d;

  logic                   adv;
  logic [SH_W-1:0]        shift_eff;
  logic [IN_W-1:0]        x_raw;
  logic signed [W2-1:0]   x_ext;
  logic signed [W2-1:0]   bias;
  logic signed [W2-1:0]   shifted;
  logic signed [W2-1:0]   clamped;
  logic                   lane_sat;
  logic [POP_W-1:0]       pop;
  logic [SUM_W-1:0]       sum;

  // The whole pipeline moves together; a stalled output freezes every stage.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_shift_d = s1_shift_q;
    s1_mode_d  = s1_mode_q;
    s1_neg_d   = s1_neg_q;
    s1_val_d   = s1_val_q;
    x_raw      = '0;
    x_ext      = '0;
    bias       = '0;

    // Shifts beyond the sample width all behave like a full-width shift.
    shift_eff = ({1'b0, in_shift} > SH_W'(IN_W)) ? SH_W'(IN_W) : {1'b0, in_shift};

    if (adv) begin
      s1_valid_d = in_valid;
      s1_shift_d = shift_eff;
      s1_mode_d  = in_mode;
      for (int i = 0; i < LANES; i++) begin
        x_raw       = in_data[i*IN_W +: IN_W];
        x_ext       = {{2{x_raw[IN_W-1]}}, x_raw};
        bias        = (shift_eff == '0) ? '0 : (W2'(1) <<< (shift_eff - SH_W'(1)));
        // Half away from zero: bias toward the sign before the floor shift.
        s1_val_d[i] = x_raw[IN_W-1] ? (x_ext - bias) : (x_ext + bias);
        s1_neg_d[i] = x_raw[IN_W-1];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    shifted     = '0;
    clamped     = '0;
    lane_sat    = 1'b0;

    if (adv) begin
      out_valid_d = s1_valid_q;
      for (int i = 0; i < LANES; i++) begin
        shifted  = s1_val_q[i] >>> s1_shift_q;
        clamped  = shifted;
        lane_sat = 1'b0;
        case (s1_mode_q)
          MODE_INT: begin
            if (shifted > M0_HI) begin
              clamped  = M0_HI;
              lane_sat = 1'b1;
            end else if (shifted < M0_LO) begin
              clamped  = M0_LO;
              lane_sat = 1'b1;
            end
          end
          MODE_INT4: begin
            if (shifted > M1_HI) begin
              clamped  = M1_HI;
              lane_sat = 1'b1;
            end else if (shifted < M1_LO) begin
              clamped  = M1_LO;
              lane_sat = 1'b1;
            end
          end
          // Binary mode looks at the raw sign, not the rounded value.
          MODE_BIN: clamped = s1_neg_q[i] ? '0 : W2'(1);
          // Bypass: plain truncation to OUT_W bits.
          default: clamped = shifted;
        endcase
        out_data_d[i*OUT_W +: OUT_W] = clamped[OUT_W-1:0];
        out_sat_d[i]                 = lane_sat;
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) begin
      pop = pop + POP_W'(out_sat_q[i]);
    end
    sum       = SUM_W'(sat_cnt_q) + SUM_W'(pop);
    sat_cnt_d = sat_cnt_q;
    if (clr_stats) begin
      sat_cnt_d = '0;
    end else if (out_valid_q && out_ready) begin
      sat_cnt_d = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_shift_q  <= '0;
      s1_mode_q   <= '0;
      s1_neg_q    <= '0;
      s1_val_q    <= '{default: '0};
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
      sat_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_shift_q  <= s1_shift_d;
      s1_mode_q   <= s1_mode_d;
      s1_neg_q    <= s1_neg_d;
      s1_val_q    <= s1_val_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign sat_cnt   = sat_cnt_q;

endmodule
